updown_mod_counter: RTL



---
 rtl/updown_mod_counter.sv | 70 +++++++
 1 files changed

// File: rtl/updown_mod_counter.sv
// Parametrised up/down modulo counter with load, wrap/saturate mode
// and a registered terminal-count flag.
module updown_mod_counter #(
    parameter int     WIDTH    = 16,
    parameter longint MODULUS  = 0,
    parameter bit     SATURATE = 1'b0
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             Enable,
    input  logic             Load,
    input  logic [WIDTH-1:0] D,
    input  logic             Up,
    output logic [WIDTH-1:0] Q,
    output logic             TC,
    output logic             Zero
);

    localparam logic [WIDTH-1:0] MAX =
        (MODULUS == 0) ? {WIDTH{1'b1}} : WIDTH'(MODULUS - 1);

    logic [WIDTH:0]   inc;
    logic [WIDTH:0]   dec;
    logic             at_max;
    logic             at_zero;
    logic [WIDTH-1:0] q_next;
    logic             tc_next;
    logic             unused_carry;

    assign inc          = {1'b0, Q} + {{WIDTH{1'b0}}, 1'b1};
    assign dec          = {1'b0, Q} - {{WIDTH{1'b0}}, 1'b1};
    assign unused_carry = inc[WIDTH] ^ dec[WIDTH];

    // Boundaries come from equality, so non-power-of-2 moduli wrap exactly.
    assign at_max  = (Q == MAX);
    assign at_zero = (Q == '0);
    assign Zero    = at_zero;

    always_comb begin
        q_next  = Q;
        tc_next = 1'b0;
        if (clr) begin
            q_next = '0;
        end else if (Load) begin
            q_next = (D > MAX) ? MAX : D;
        end else if (Enable) begin
            if (Up) begin
                if (at_max) begin
                    q_next  = SATURATE ? MAX : '0;
                    tc_next = 1'b1;
                end else begin
                    q_next = inc[WIDTH-1:0];
                end
            end else begin
                if (at_zero) begin
                    q_next  = SATURATE ? '0 : MAX;
                    tc_next = 1'b1;
                end else begin
                    q_next = dec[WIDTH-1:0];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        Q  <= q_next;
        TC <= tc_next;
    end

endmodule
